// File: rtl/sgdmac_pkg.sv
// Shared SG DMA definitions: AXI burst/size encodings and the AR payload record.
package sgdmac_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } axi_burst_e;

  localparam logic [2:0] SIZE_1B   = 3'd0;
  localparam logic [2:0] SIZE_2B   = 3'd1;
  localparam logic [2:0] SIZE_4B   = 3'd2;
  localparam logic [2:0] SIZE_8B   = 3'd3;
  localparam logic [2:0] SIZE_16B  = 3'd4;
  localparam logic [2:0] SIZE_32B  = 3'd5;
  localparam logic [2:0] SIZE_64B  = 3'd6;
  localparam logic [2:0] SIZE_128B = 3'd7;

  // Address field is sized for the widest supported bus; narrower users pad.
  localparam int unsigned AR_ADDR_MAX_W = 64;

  typedef struct packed {
    logic [AR_ADDR_MAX_W-1:0] addr;
    logic [3:0]               len;
    logic [2:0]               size;
    logic [1:0]               burst;
  } ar_payload_t;

endpackage

// File: rtl/sgdmac_ar_rr_mux_if.sv
// AR/R bundle of the read mux: per-master request/response side and the AXI side.
// The 'slave' view belongs to the mux (it serves the requesters), 'master' to its environment.
interface sgdmac_ar_rr_mux_if #(
  parameter int unsigned N_MASTERS  = 4,
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned ADDR_WIDTH = 32
);

  logic [N_MASTERS-1:0]            m_arvalid_i;
  logic [N_MASTERS-1:0]            m_arready_o;
  logic [N_MASTERS*ADDR_WIDTH-1:0] m_araddr_i;
  logic [N_MASTERS*4-1:0]          m_arlen_i;
  logic [N_MASTERS*3-1:0]          m_arsize_i;
  logic [N_MASTERS*2-1:0]          m_arburst_i;

  logic [ID_WIDTH-1:0]             arid_o;
  logic [ADDR_WIDTH-1:0]           araddr_o;
  logic [3:0]                      arlen_o;
  logic [2:0]                      arsize_o;
  logic [1:0]                      arburst_o;
  logic                            arvalid_o;
  logic                            arready_i;

  logic [ID_WIDTH-1:0]             rid_i;
  logic                            rvalid_i;
  logic                            rlast_i;
  logic                            rready_o;

  logic [N_MASTERS-1:0]            m_rvalid_o;
  logic [N_MASTERS-1:0]            m_rlast_o;
  logic [N_MASTERS-1:0]            m_rready_i;

  logic                            err_o;
  logic                            busy_o;

  modport slave (
    input  m_arvalid_i, m_araddr_i, m_arlen_i, m_arsize_i, m_arburst_i,
    output m_arready_o,
    output arid_o, araddr_o, arlen_o, arsize_o, arburst_o, arvalid_o,
    input  arready_i,
    input  rid_i, rvalid_i, rlast_i,
    output rready_o,
    output m_rvalid_o, m_rlast_o,
    input  m_rready_i,
    output err_o, busy_o
  );

  modport master (
    output m_arvalid_i, m_araddr_i, m_arlen_i, m_arsize_i, m_arburst_i,
    input  m_arready_o,
    input  arid_o, araddr_o, arlen_o, arsize_o, arburst_o, arvalid_o,
    output arready_i,
    output rid_i, rvalid_i, rlast_i,
    input  rready_o,
    input  m_rvalid_o, m_rlast_o,
    output m_rready_i,
    input  err_o, busy_o
  );

endinterface

// File: rtl/sgdmac_rr_arbiter.sv
// Combinational round-robin arbiter: first requester above 'last', wrapping.
module sgdmac_rr_arbiter #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  int unsigned   cand;
  logic [IW-1:0] cand_idx;
  logic          found;

  // Scan last+1 .. last+N modulo N and take the first request hit.
  always_comb begin
    gnt      = '0;
    idx      = '0;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned i = 1; i <= N; i++) begin
      cand     = (32'(last) + i) % N;
      cand_idx = IW'(cand);
      if (!found && req[cand_idx]) begin
        found         = 1'b1;
        gnt[cand_idx] = 1'b1;
        idx           = cand_idx;
      end
    end
  end

endmodule

// File: rtl/sgdmac_ar_rr_mux.sv
// AXI read-address mux with round-robin grant, registered AR stage,
// per-master outstanding-burst limits and rid-indexed R control routing.
module sgdmac_ar_rr_mux
  import sgdmac_pkg::*;
#(
  parameter int unsigned N_MASTERS  = 4,
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned MAX_OUT    = 4
) (
  input logic               clk,
  input logic               rst,
  sgdmac_ar_rr_mux_if.slave bus
);

  localparam int unsigned     IDX_W   = $clog2(N_MASTERS);
  localparam int unsigned     CNT_W   = $clog2(MAX_OUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUT);

  logic [CNT_W-1:0]     out_cnt [N_MASTERS];
  logic [IDX_W-1:0]     last;
  logic                 ar_valid_q;
  ar_payload_t          ar_q;
  ar_payload_t          ar_d;
  logic [ID_WIDTH-1:0]  arid_q;
  logic                 err_q;

  logic [N_MASTERS-1:0] eligible;
  logic [N_MASTERS-1:0] gnt;
  logic [IDX_W-1:0]     gnt_idx;
  logic [N_MASTERS-1:0] arready;
  logic                 reg_free;
  logic                 grant;

  logic [N_MASTERS-1:0] rvalid;
  logic [N_MASTERS-1:0] rlast;
  logic [N_MASTERS-1:0] dec;
  logic                 rready;
  logic                 rid_known;
  logic                 any_out;
  logic                 addr_pad_unused;

  // A master may compete only while it is below its outstanding limit.
  always_comb begin
    eligible = '0;
    for (int unsigned k = 0; k < N_MASTERS; k++) begin
      eligible[k] = bus.m_arvalid_i[k] && (out_cnt[k] < CNT_MAX);
    end
  end

  assign reg_free = !ar_valid_q || bus.arready_i;

  sgdmac_rr_arbiter #(
    .N  (N_MASTERS),
    .IW (IDX_W)
  ) u_arb (
    .req  (eligible),
    .last (last),
    .gnt  (gnt),
    .idx  (gnt_idx)
  );

  // Grants are only issued into a free output register and never during reset.
  assign arready = (reg_free && !rst) ? gnt : '0;
  assign grant   = |arready;

  // Select the winning master's payload from the packed request buses.
  always_comb begin
    ar_d       = '0;
    ar_d.addr  = AR_ADDR_MAX_W'(bus.m_araddr_i[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH]);
    ar_d.len   = bus.m_arlen_i[gnt_idx*4 +: 4];
    ar_d.size  = bus.m_arsize_i[gnt_idx*3 +: 3];
    ar_d.burst = bus.m_arburst_i[gnt_idx*2 +: 2];
  end

  // AR output register: load on grant, hold under backpressure, drop when drained.
  always_ff @(posedge clk) begin
    if (rst) begin
      ar_valid_q <= 1'b0;
      ar_q       <= '0;
      arid_q     <= '0;
      last       <= IDX_W'(N_MASTERS - 1);
    end else if (grant) begin
      ar_valid_q <= 1'b1;
      ar_q       <= ar_d;
      arid_q     <= ID_WIDTH'(gnt_idx);
      last       <= gnt_idx;
    end else if (reg_free) begin
      ar_valid_q <= 1'b0;
    end
  end

  // R control routing by rid; unknown ids are drained with rready held high.
  always_comb begin
    rvalid    = '0;
    rlast     = '0;
    dec       = '0;
    rready    = 1'b1;
    rid_known = 1'b0;
    for (int unsigned k = 0; k < N_MASTERS; k++) begin
      if (bus.rid_i == ID_WIDTH'(k)) begin
        rid_known = 1'b1;
        rvalid[k] = bus.rvalid_i;
        rlast[k]  = bus.rlast_i;
        rready    = bus.m_rready_i[k];
        dec[k]    = bus.rvalid_i && bus.rlast_i && bus.m_rready_i[k];
      end
    end
  end

  // Outstanding-burst counters: +1 on grant, -1 on accepted last beat, both cancel.
  always_ff @(posedge clk) begin
    for (int unsigned k = 0; k < N_MASTERS; k++) begin
      if (rst) begin
        out_cnt[k] <= '0;
      end else if (arready[k] && !dec[k]) begin
        out_cnt[k] <= out_cnt[k] + 1'b1;
      end else if (dec[k] && !arready[k]) begin
        out_cnt[k] <= out_cnt[k] - 1'b1;
      end
    end
  end

  // Sticky flag for response beats carrying an id no master owns.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (bus.rvalid_i && !rid_known) begin
      err_q <= 1'b1;
    end
  end

  // Any master with bursts still in flight keeps the block busy.
  always_comb begin
    any_out = 1'b0;
    for (int unsigned k = 0; k < N_MASTERS; k++) begin
      any_out = any_out || (out_cnt[k] != '0);
    end
  end

  // Pad bits of the package-wide address field beyond ADDR_WIDTH carry nothing.
  assign addr_pad_unused = ^ar_q.addr;

  assign bus.m_arready_o = arready;
  assign bus.arvalid_o   = ar_valid_q;
  assign bus.arid_o      = arid_q;
  assign bus.araddr_o    = ar_q.addr[ADDR_WIDTH-1:0];
  assign bus.arlen_o     = ar_q.len;
  assign bus.arsize_o    = ar_q.size;
  assign bus.arburst_o   = ar_q.burst;
  assign bus.rready_o    = rready;
  assign bus.m_rvalid_o  = rvalid;
  assign bus.m_rlast_o   = rlast;
  assign bus.err_o       = err_q;
  assign bus.busy_o      = ar_valid_q || any_out;

  for (genvar k = 0; k < N_MASTERS; k++) begin : g_cnt_chk
    assert property (@(posedge clk) disable iff (rst)
      !(arready[k] && !dec[k] && out_cnt[k] == CNT_MAX));
    assert property (@(posedge clk) disable iff (rst)
      !(dec[k] && !arready[k] && out_cnt[k] == '0));
  end

endmodule

// File: doc/sgdmac_ar_rr_mux.md
# sgdmac_ar_rr_mux

Parametrised AXI read-address multiplexer and read-response router for the SG DMA controller. It generalises the fixed two-requester read arbitration and `rid`-indexed `rready` selection to `N_MASTERS` requesters, with these additions:
- round-robin fairness,
- a registered AR output stage,
- per-master outstanding-burst limits,
- per-master gated `rvalid`/`rlast`,
- a sticky error for unknown response IDs.

It sits between the descriptor fetcher, the read engine(s) and the external AXI AR/R channels.

## Interface
Parameters:
- `N_MASTERS`, 4, number of requesting engines (2..16)
- `ID_WIDTH`, 4, AXI ID width; must satisfy 2^`ID_WIDTH` >= `N_MASTERS`
- `ADDR_WIDTH`, 32, address width
- `MAX_OUT`, 4, maximum outstanding read bursts per master (1..15)

Ports:
- `clk` in 1: clock
- `rst` in 1: reset; one clock, reset is synchronous and active-high
- `m_arvalid_i` in `N_MASTERS`: per-master AR valid
- `m_arready_o` out `N_MASTERS`: per-master AR ready (grant)
- `m_araddr_i` in `N_MASTERS*ADDR_WIDTH`: packed addresses, master k at bits [k*`ADDR_WIDTH` +: `ADDR_WIDTH`]
- `m_arlen_i` in `N_MASTERS*4`, `m_arsize_i` in `N_MASTERS*3`, `m_arburst_i` in `N_MASTERS*2`: packed the same way
- `arid_o` out `ID_WIDTH`; `araddr_o` out `ADDR_WIDTH`; `arlen_o` out 4; `arsize_o` out 3; `arburst_o` out 2: AXI AR payload
- `arvalid_o` out 1, `arready_i` in 1: AXI AR handshake
- `rid_i` in `ID_WIDTH`, `rvalid_i` in 1, `rlast_i` in 1, `rready_o` out 1: AXI R control. `rdata_i`/`rresp_i` bypass this block and go straight to the masters.
- `m_rvalid_o` out `N_MASTERS`, `m_rlast_o` out `N_MASTERS`, `m_rready_i` in `N_MASTERS`: per-master R control
- `err_o` out 1: sticky flag, unknown `rid_i` seen
- `busy_o` out 1: any burst outstanding, or `arvalid_o` high

## Operation
- Master k is **eligible** when `m_arvalid_i[k]` is high and `out_cnt[k]` < `MAX_OUT`.
- **Output register is free** when `arvalid_o` is 0, or when `arvalid_o & arready_i` holds this cycle.
- **Grant:** when the register is free and at least one master is eligible, grant exactly one master.
  - Pick the first eligible index searching upward from `last+1`, wrapping modulo `N_MASTERS`.
  - `m_arready_o[g]` = 1 combinationally in that cycle; all other `m_arready_o` bits are 0.
  - At the clock edge: load the payload of master g into the register, set `arid_o` = g zero-extended, set `arvalid_o` = 1, set `last` = g.
  - If the register is freed and nothing is eligible: `arvalid_o` goes to 0 next cycle.
- **Payload stability:** the payload is held stable while `arvalid_o & ~arready_i`.
- **Outstanding counters:**
  - `out_cnt[g]` increments on grant.
  - `out_cnt[rid_i]` decrements on `rvalid_i & rready_o & rlast_i` with `rid_i` < `N_MASTERS`.
  - Increment and decrement of the same counter in the same cycle leave it unchanged.
  - Counter width is `$clog2(MAX_OUT+1)`. Overflow or underflow is impossible by construction; an assertion checks this.
- **R routing, `rid_i` < `N_MASTERS`:**
  - `m_rvalid_o[rid_i]` = `rvalid_i`; `m_rlast_o[rid_i]` = `rlast_i`; all other bits are 0.
  - `rready_o` = `m_rready_i[rid_i]`.
- **R routing, `rid_i` >= `N_MASTERS`:**
  - `rready_o` = 1, so the beat is drained.
  - No `m_rvalid_o` bit is set.
  - `err_o` is set on `rvalid_i`; it is cleared only by `rst`.
- `busy_o` = `arvalid_o` | (any `out_cnt` != 0).

## Timing
- **Reset values:**
  - `arvalid_o` = 0; `arid_o`, `araddr_o`, `arlen_o`, `arsize_o`, `arburst_o` = 0.
  - All `out_cnt` = 0; `err_o` = 0; `busy_o` = 0.
  - `last` = `N_MASTERS`-1, so master 0 wins first.
  - `m_arready_o` = 0 in the reset cycle.
- **AR latency:** 1 cycle from grant (`m_arvalid_i` & `m_arready_o`) to `arvalid_o`.
- **AR throughput:** with `arready_i` held high, one grant per cycle back-to-back.
- **R path:** purely combinational, zero latency. The `rid_i` → `rready_o` path carries no register.
- **Reset mid-operation:** all state is cleared immediately; in-flight bursts are forgotten. Masters and the slave must be reset together.

## Structure
- **Shared package `sgdmac_pkg`:**
  - AXI burst encodings (`BURST_FIXED`/`INCR`/`WRAP`)
  - `arsize` encoding constants
  - struct `ar_payload_t` (addr, len, size, burst)
- **Sub-module `sgdmac_rr_arbiter`:** parametrised `N`. Inputs: `req[N]`, `last` pointer. Outputs: one-hot `gnt[N]` and its binary index. Purely combinational.
- **Top level of this block:** holds the output register, the counters, R routing and the error flag.

## Test plan
- **Single request:** after reset, `N_MASTERS`=4 and `m_arvalid_i`=0010 with addr 0x1000, len 3 → next cycle `arvalid_o`=1, `arid_o`=1, `araddr_o`=0x1000, `arlen_o`=3.
- **Round-robin:** all four masters request continuously, `arready_i`=1 → `arid_o` sequence 0,1,2,3,0,1, one per cycle.
- **Backpressure:** `arready_i`=0 for 5 cycles → payload stable, no `m_arready_o` asserted; on release exactly one handshake occurs, then the next grant follows.
- **Outstanding limit:** `MAX_OUT`=2, master 2 issues 2 bursts with no R → master 2 is no longer granted. An R beat with `rid_i`=2, `rlast_i`=1 → master 2 is granted again the next cycle.
- **R routing:** `rid_i`=3, `rvalid_i`=1, `m_rready_i`=1000 → `m_rvalid_o`=1000, `rready_o`=1. With `m_rready_i`=0000 → `rready_o`=0.
- **Bad ID and reset:** `rid_i`=9 with `N_MASTERS`=4 → `rready_o`=1, `m_rvalid_o`=0, `err_o`=1 sticky. `rst` pulse → `err_o`, `busy_o`, `arvalid_o` all 0.
